range_scan_ctrl: RTL and testbench

Time-multiplexed range checker for fixed-point real signals. Scans `N_CH` fixed-point channels round-robin through one shared signed comparator against programmable inclusive limits. Sets sticky per-channel violation flags and reports the first unacknowledged violation over a valid/ready interface. It is the synthesizable, shared-resource counterpart to per-signal simulation range assertions, and is used where many real-valued nets on an FPGA emulation target need monitoring.

---
 rtl/range_scan_pkg.sv | 18 +
 rtl/range_scan_ctrl_if.sv | 13 +
 rtl/range_cmp.sv | 11 +
 rtl/range_scan_ctrl.sv | 141 ++++++++++++++
 tb/tb_range_scan_ctrl.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/range_scan_pkg.sv
// Shared types and helpers for the range_scan_ctrl slice.
package range_scan_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  function automatic int unsigned ptr_w(input int unsigned n);
    return unsigned'($clog2(n));
  endfunction

  // Fixed-point word to real, scaled by 2**e; diagnostic printing only.
  function automatic real fx_to_real(input logic signed [63:0] v, input int e);
    return real'(v) * (2.0 ** e);
  endfunction

endpackage

// File: rtl/range_scan_ctrl_if.sv
// Fault-record valid/ready channel between range_scan_ctrl and its consumer.
interface range_scan_ctrl_if #(
  parameter int unsigned CH_W  = 2,
  parameter int unsigned WIDTH = 16
);
  logic             fault_valid;
  logic             fault_ready;
  logic [CH_W-1:0]  fault_ch;
  logic [WIDTH-1:0] fault_val;

  modport master (output fault_valid, output fault_ch, output fault_val, input fault_ready);
  modport slave  (input fault_valid, input fault_ch, input fault_val, output fault_ready);
endinterface

// File: rtl/range_cmp.sv
// Shared signed inclusive-window comparator, purely combinational.
module range_cmp #(
  parameter int unsigned WIDTH = 16
) (
  input  logic signed [WIDTH-1:0] val,
  input  logic signed [WIDTH-1:0] lo,
  input  logic signed [WIDTH-1:0] hi,
  output logic                    out_of_range
);
  assign out_of_range = (val < lo) || (val > hi);
endmodule

// File: rtl/range_scan_ctrl.sv
// Round-robin range checker: one comparator scans N_CH channels, sticky flags, fault record.
// Optional macro RANGE_SCAN_CTRL_FATAL_EN: print each violation and end simulation.
module range_scan_ctrl
  import range_scan_pkg::*;
#(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned WIDTH    = 16,
  parameter int          EXPONENT = -8,
  parameter int unsigned DROP_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    clear,
  input  logic [N_CH*WIDTH-1:0]   in_flat,
  input  logic signed [WIDTH-1:0] lo,
  input  logic signed [WIDTH-1:0] hi,
  output logic [N_CH-1:0]         viol_flags,
  range_scan_ctrl_if.master       fault,
  output logic [DROP_W-1:0]       drop_cnt,
  output logic                    scan_done,
  output logic                    cfg_err
);

  localparam int unsigned CH_W = ptr_w(N_CH);

  if (N_CH < 2 || EXPONENT < -60 || EXPONENT > 60) begin : g_param_err
    $error("range_scan_ctrl: unsupported N_CH or EXPONENT");
  end

  scan_state_t             r_state, w_state_nxt;
  logic [CH_W-1:0]         r_ptr, w_ptr_nxt;
  logic                    r_done, w_done_nxt;
  logic [N_CH-1:0]         r_flags, w_flags_nxt;
  logic                    r_fv, w_fv_nxt;
  logic [CH_W-1:0]         r_fch, w_fch_nxt;
  logic [WIDTH-1:0]        r_fval, w_fval_nxt;
  logic [DROP_W-1:0]       r_drop, w_drop_nxt;

  logic signed [WIDTH-1:0] w_ch [N_CH];
  logic signed [WIDTH-1:0] w_val;
  logic                    w_oor;
  logic                    w_viol;
  logic                    w_last;
  logic                    w_accept;
  logic                    w_slot_free;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign w_ch[k] = in_flat[k*WIDTH +: WIDTH];
  end

  assign w_val = w_ch[r_ptr];

  range_cmp #(.WIDTH(WIDTH)) u_cmp (
    .val          (w_val),
    .lo           (lo),
    .hi           (hi),
    .out_of_range (w_oor)
  );

  // An inverted window would flag everything, so checks are suppressed while it is invalid.
  assign cfg_err     = lo > hi;
  assign w_viol      = (r_state == SCAN) && !cfg_err && w_oor;
  assign w_last      = r_ptr == CH_W'(N_CH - 1);
  assign w_accept    = r_fv && fault.fault_ready;
  assign w_slot_free = !r_fv || w_accept || clear;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_done_nxt  = 1'b0;
    w_flags_nxt = clear ? '0 : r_flags;
    w_fv_nxt    = r_fv && !w_accept && !clear;
    w_fch_nxt   = r_fch;
    w_fval_nxt  = r_fval;
    w_drop_nxt  = clear ? '0 : r_drop;

    unique case (r_state)
      IDLE: if (en && !cfg_err) w_state_nxt = SCAN;
      SCAN: begin
        w_ptr_nxt  = w_last ? '0 : r_ptr + CH_W'(1);
        w_done_nxt = w_last;
        if (w_last && (!en || cfg_err)) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase

    // Same-cycle violation beats clear and a completing handshake.
    if (w_viol) begin
      w_flags_nxt[r_ptr] = 1'b1;
      if (w_slot_free) begin
        w_fv_nxt   = 1'b1;
        w_fch_nxt  = r_ptr;
        w_fval_nxt = w_val;
      end else if (w_drop_nxt != '1) begin
        w_drop_nxt = w_drop_nxt + DROP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_done  <= 1'b0;
      r_flags <= '0;
      r_fv    <= 1'b0;
      r_fch   <= '0;
      r_fval  <= '0;
      r_drop  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_done  <= w_done_nxt;
      r_flags <= w_flags_nxt;
      r_fv    <= w_fv_nxt;
      r_fch   <= w_fch_nxt;
      r_fval  <= w_fval_nxt;
      r_drop  <= w_drop_nxt;
    end
  end

  assign viol_flags        = r_flags;
  assign scan_done         = r_done;
  assign drop_cnt          = r_drop;
  assign fault.fault_valid = r_fv;
  assign fault.fault_ch    = r_fch;
  assign fault.fault_val   = r_fval;

`ifdef RANGE_SCAN_CTRL_FATAL_EN
  always_ff @(posedge clk) begin
    if (rst_n && w_viol) begin
      $display("range_scan_ctrl: ch %0d value %f outside [%f, %f]", r_ptr,
               fx_to_real(64'(w_val), EXPONENT), fx_to_real(64'(lo), EXPONENT),
               fx_to_real(64'(hi), EXPONENT));
      $finish;
    end
  end
`endif

endmodule

// File: tb/tb_range_scan_ctrl.sv
// Directed bench for range_scan_ctrl; second instance with DROP_W=2 checks saturation.
module tb_range_scan_ctrl;

  logic               clk;
  logic               rst_n;
  logic               en;
  logic               clear;
  logic [63:0]        in_flat;
  logic signed [15:0] lo;
  logic signed [15:0] hi;
  logic [3:0]         viol_flags, viol_flags2;
  logic [7:0]         drop_cnt;
  logic [1:0]         drop_cnt2;
  logic               scan_done, scan_done2;
  logic               cfg_err, cfg_err2;

  int n_assert = 0;
  int n_fail   = 0;

  range_scan_ctrl_if #(.CH_W(2), .WIDTH(16)) f_if ();
  range_scan_ctrl_if #(.CH_W(2), .WIDTH(16)) f2_if ();

  range_scan_ctrl #(.N_CH(4), .WIDTH(16), .EXPONENT(-8), .DROP_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .in_flat(in_flat),
    .lo(lo), .hi(hi), .viol_flags(viol_flags), .fault(f_if.master),
    .drop_cnt(drop_cnt), .scan_done(scan_done), .cfg_err(cfg_err)
  );

  range_scan_ctrl #(.N_CH(4), .WIDTH(16), .EXPONENT(-8), .DROP_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .in_flat(in_flat),
    .lo(lo), .hi(hi), .viol_flags(viol_flags2), .fault(f2_if.master),
    .drop_cnt(drop_cnt2), .scan_done(scan_done2), .cfg_err(cfg_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_ch(input int k, input logic [15:0] v);
    in_flat[k*16 +: 16] = v;
  endtask

  // Advance until the edge that reports end of pass; afterwards ch0 is being checked.
  task automatic to_pass_start();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick(1);
      seen = scan_done;
    end
    chk("sync_done", 32'(seen), 32'd1);
  endtask

  int pulses;
  int pos [3];

  initial begin
    rst_n = 1'b0; en = 1'b0; clear = 1'b0; in_flat = '0;
    lo = -16'sd256; hi = 16'sd256;
    f_if.fault_ready = 1'b0; f2_if.fault_ready = 1'b0;
    pos[0] = 0; pos[1] = 0; pos[2] = 0;
    tick(3);

    chk("rst_flags", 32'(viol_flags), 32'h0);
    chk("rst_valid", 32'(f_if.fault_valid), 32'h0);
    chk("rst_ch", 32'(f_if.fault_ch), 32'h0);
    chk("rst_val", 32'(f_if.fault_val), 32'h0);
    chk("rst_drop", 32'(drop_cnt), 32'h0);
    chk("rst_done", 32'(scan_done), 32'h0);
    chk("rst_cfg_err", 32'(cfg_err), 32'h0);

    // In-range scan
    rst_n = 1'b1; en = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 13; i++) begin
      tick(1);
      if (scan_done) begin
        if (pulses < 3) pos[pulses] = i;
        pulses++;
      end
    end
    chk("inr_pulses", 32'(pulses), 32'd3);
    chk("inr_pos0", 32'(pos[0]), 32'd5);
    chk("inr_pos1", 32'(pos[1]), 32'd9);
    chk("inr_pos2", 32'(pos[2]), 32'd13);
    chk("inr_flags", 32'(viol_flags), 32'h0);
    chk("inr_valid", 32'(f_if.fault_valid), 32'h0);

    // Single violation on ch2 with handshake
    set_ch(2, 16'd300);
    tick(2);
    chk("sv_flags_pre", 32'(viol_flags), 32'h0);
    tick(1);
    chk("sv_flags", 32'(viol_flags), 32'h4);
    chk("sv_valid", 32'(f_if.fault_valid), 32'h1);
    chk("sv_ch", 32'(f_if.fault_ch), 32'h2);
    chk("sv_val", 32'(f_if.fault_val), 32'h012C);
    set_ch(2, 16'd0);
    tick(5);
    chk("sv_hold_valid", 32'(f_if.fault_valid), 32'h1);
    chk("sv_hold_ch", 32'(f_if.fault_ch), 32'h2);
    chk("sv_hold_val", 32'(f_if.fault_val), 32'h012C);
    f_if.fault_ready = 1'b1;
    tick(1);
    f_if.fault_ready = 1'b0;
    chk("sv_acc_valid", 32'(f_if.fault_valid), 32'h0);
    to_pass_start();
    chk("sv_sticky", 32'(viol_flags), 32'h4);
    chk("sv_drop", 32'(drop_cnt), 32'h0);

    // Drop counting over three passes
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    chk("clr_flags", 32'(viol_flags), 32'h0);
    chk("clr_valid2", 32'(f2_if.fault_valid), 32'h0);
    to_pass_start();
    set_ch(1, 16'hFED4);
    set_ch(3, 16'hFED4);
    tick(12);
    chk("drp_valid", 32'(f_if.fault_valid), 32'h1);
    chk("drp_ch", 32'(f_if.fault_ch), 32'h1);
    chk("drp_val", 32'(f_if.fault_val), 32'hFED4);
    chk("drp_cnt", 32'(drop_cnt), 32'd5);
    chk("drp_flags", 32'(viol_flags), 32'hA);
    chk("drp_sat", 32'(drop_cnt2), 32'd3);
    chk("drp_ch2", 32'(f2_if.fault_ch), 32'h1);
    set_ch(1, 16'd0);
    set_ch(3, 16'd0);

    // Clear colliding with a ch1 violation
    set_ch(1, 16'hFE70);
    tick(1);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    chk("col_flags", 32'(viol_flags), 32'h2);
    chk("col_valid", 32'(f_if.fault_valid), 32'h1);
    chk("col_ch", 32'(f_if.fault_ch), 32'h1);
    chk("col_val", 32'(f_if.fault_val), 32'hFE70);
    chk("col_drop", 32'(drop_cnt), 32'h0);
    chk("col_drop2", 32'(drop_cnt2), 32'h0);
    set_ch(1, 16'd0);
    f_if.fault_ready = 1'b1;
    tick(1);
    f_if.fault_ready = 1'b0;
    chk("col_acc", 32'(f_if.fault_valid), 32'h0);

    // Bad configuration mid-pass
    to_pass_start();
    tick(1);
    lo = 16'sd10; hi = 16'sd5;
    set_ch(0, 16'h03E8);
    #1;
    chk("cfg_err_hi", 32'(cfg_err), 32'h1);
    tick(2);
    chk("cfg_done_pre", 32'(scan_done), 32'h0);
    tick(1);
    chk("cfg_done", 32'(scan_done), 32'h1);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (scan_done) pulses++;
    end
    chk("cfg_idle_pulses", 32'(pulses), 32'd0);
    chk("cfg_frozen", 32'(viol_flags), 32'h2);
    chk("cfg_valid", 32'(f_if.fault_valid), 32'h0);
    lo = -16'sd256; hi = 16'sd256;
    #1;
    chk("cfg_err_lo", 32'(cfg_err), 32'h0);
    tick(1);
    chk("res_flags_pre", 32'(viol_flags), 32'h2);
    tick(1);
    chk("res_flags", 32'(viol_flags), 32'h3);
    chk("res_ch", 32'(f_if.fault_ch), 32'h0);
    chk("res_val", 32'(f_if.fault_val), 32'h03E8);
    set_ch(0, 16'd0);
    f_if.fault_ready = 1'b1;
    tick(1);
    f_if.fault_ready = 1'b0;

    // Disable mid-pass: pass still finishes
    to_pass_start();
    tick(1);
    en = 1'b0;
    tick(2);
    chk("dis_done_pre", 32'(scan_done), 32'h0);
    tick(1);
    chk("dis_done", 32'(scan_done), 32'h1);
    set_ch(2, 16'h01F4);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (scan_done) pulses++;
    end
    chk("dis_idle_pulses", 32'(pulses), 32'd0);
    chk("dis_flags", 32'(viol_flags), 32'h3);
    set_ch(2, 16'd0);

    // Reset mid-pass at ptr=2
    set_ch(1, 16'h012C);
    en = 1'b1;
    tick(3);
    chk("mr_valid_pre", 32'(f_if.fault_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mr_flags", 32'(viol_flags), 32'h0);
    chk("mr_valid", 32'(f_if.fault_valid), 32'h0);
    chk("mr_ch", 32'(f_if.fault_ch), 32'h0);
    chk("mr_val", 32'(f_if.fault_val), 32'h0);
    chk("mr_drop", 32'(drop_cnt), 32'h0);
    chk("mr_done", 32'(scan_done), 32'h0);
    set_ch(1, 16'd0);
    set_ch(0, 16'h02BC);
    tick(2);
    chk("mr_done_hold", 32'(scan_done), 32'h0);
    rst_n = 1'b1;
    tick(2);
    chk("mr_next_flags", 32'(viol_flags), 32'h1);
    chk("mr_next_ch", 32'(f_if.fault_ch), 32'h0);
    chk("mr_next_val", 32'(f_if.fault_val), 32'h02BC);
    pulses = 0;
    for (int i = 0; i < 2; i++) begin
      tick(1);
      if (scan_done) pulses++;
    end
    chk("mr_no_early_done", 32'(pulses), 32'd0);
    tick(1);
    chk("mr_first_done", 32'(scan_done), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
